// File: rtl/mem_stage_pkg.sv
// MEM stage shared types: opcodes, func3 encodings, FSM states
// and byte-enable / alignment helpers.
package mem_stage_pkg;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  typedef enum logic [2:0] {
    F3_B   = 3'd0,
    F3_H   = 3'd1,
    F3_W   = 3'd2,
    F3_D   = 3'd3,
    F3_BU  = 3'd4,
    F3_HU  = 3'd5,
    F3_WU  = 3'd6,
    F3_RSV = 3'd7
  } f3_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT_R,
    S_DRAIN
  } state_e;

  // sz: log2 of access size in bytes
  function automatic logic [7:0] be_mask(
    input logic [1:0] sz,
    input logic [2:0] lane
  );
    logic [7:0] m;
    unique case (sz)
      2'd0:    m = 8'h01 << lane;
      2'd1:    m = 8'h03 << lane;
      2'd2:    m = 8'h0F << lane;
      default: m = 8'hFF;
    endcase
    return m;
  endfunction

  function automatic logic misalign(
    input logic [1:0] sz,
    input logic [2:0] a
  );
    logic r;
    unique case (sz)
      2'd0:    r = 1'b0;
      2'd1:    r = a[0];
      2'd2:    r = |a[1:0];
      default: r = |a;
    endcase
    return r;
  endfunction

  function automatic logic f3_ok(
    input logic       ld,
    input logic [2:0] f3,
    input logic       x64
  );
    logic ok;
    unique case (f3)
      F3_B, F3_H, F3_W: ok = 1'b1;
      F3_D:             ok = x64;
      F3_BU, F3_HU:     ok = ld;
      F3_WU:            ok = ld & x64;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mem_stage_hs_ld_align.sv
// Load data lane select and sign/zero extension.
module mem_ld_align
  import mem_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rdata_i,
  input  logic [2:0]      lane_i,
  input  logic [2:0]      f3_i,
  output logic [XLEN-1:0] data_o
);

  logic [XLEN-1:0] sh;

  assign sh = rdata_i >> {lane_i, 3'b000};

  always_comb begin
    data_o = '0;
    unique case (f3_i)
      F3_B:    data_o = XLEN'($signed(sh[7:0]));
      F3_H:    data_o = XLEN'($signed(sh[15:0]));
      F3_W:    data_o = XLEN'($signed(sh[31:0]));
      F3_BU:   data_o = XLEN'(sh[7:0]);
      F3_HU:   data_o = XLEN'(sh[15:0]);
      F3_WU:   data_o = XLEN'(sh[31:0]);
      default: data_o = sh;
    endcase
  end

endmodule

// File: rtl/mem_stage_hs.sv
// MEM pipeline stage: EX->WB handshake, data memory
// request/grant/response, lane steering and flush handling.
module mem_stage_hs
  import mem_stage_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic [XLEN-1:0]   alu_i,
  input  logic [XLEN-1:0]   st_data_i,
  input  logic [31:0]       inst_i,
  input  logic              flush_i,
  output logic              dmem_req_o,
  output logic              dmem_we_o,
  output logic [ADDR_W-1:0] dmem_addr_o,
  output logic [XLEN/8-1:0] dmem_be_o,
  output logic [XLEN-1:0]   dmem_wdata_o,
  input  logic              dmem_gnt_i,
  input  logic              dmem_rvalid_i,
  input  logic [XLEN-1:0]   dmem_rdata_i,
  output logic              wb_valid_o,
  input  logic              wb_ready_i,
  output logic [XLEN-1:0]   wb_alu_o,
  output logic [ADDR_W-1:0] wb_pc4_o,
  output logic [XLEN-1:0]   wb_ld_o,
  output logic [31:0]       wb_inst_o,
  output logic              wb_err_o
);

  localparam int   NB  = XLEN / 8;
  localparam int   LB  = $clog2(NB);
  localparam logic X64 = (XLEN == 64);

  state_e            state_q;
  logic              req_q, we_q;
  logic [NB-1:0]     be_q, be_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [XLEN-1:0]   alu_q;
  logic [ADDR_W-1:0] pc4_q, pc4_d;
  logic [31:0]       inst_q;
  logic              wb_valid_q, wb_err_q;
  logic [XLEN-1:0]   wb_alu_q, wb_ld_q;
  logic [ADDR_W-1:0] wb_pc4_q;
  logic [31:0]       wb_inst_q;

  logic            is_ld, is_st, is_mem, bad, acc;
  logic [2:0]      f3, lane;
  logic [1:0]      sz;
  logic [XLEN-1:0] ld_data;

  always_comb begin
    is_ld = 1'b0;
    is_st = 1'b0;
    unique case (1'b1)
      inst_i[6:0] == OP_LOAD:  is_ld = 1'b1;
      inst_i[6:0] == OP_STORE: is_st = 1'b1;
      default: ;
    endcase
  end

  assign is_mem = is_ld | is_st;
  assign f3     = inst_i[14:12];
  assign sz     = f3[1:0];
  assign lane   = 3'(alu_i[LB-1:0]);
  assign bad    = is_mem & (~f3_ok(is_ld, f3, X64)
                  | misalign(sz, alu_i[2:0]));

  assign in_ready_o = (state_q == S_IDLE)
                    & (~wb_valid_q | wb_ready_i);
  assign acc        = in_valid_i & in_ready_o & ~flush_i;

  assign be_d   = NB'(be_mask(sz, lane));
  assign addr_d = ADDR_W'(alu_i) & ~ADDR_W'(NB - 1);
  assign pc4_d  = pc_i + ADDR_W'(4);

  always_comb begin
    wdata_d = st_data_i;
    unique case (sz)
      2'd0:    wdata_d = {NB{st_data_i[7:0]}};
      2'd1:    wdata_d = {(XLEN/16){st_data_i[15:0]}};
      2'd2:    wdata_d = {(XLEN/32){st_data_i[31:0]}};
      default: wdata_d = st_data_i;
    endcase
  end

  mem_ld_align #(.XLEN(XLEN)) u_align (
    .rdata_i (dmem_rdata_i),
    .lane_i  (3'(alu_q[LB-1:0])),
    .f3_i    (inst_q[14:12]),
    .data_o  (ld_data)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      be_q       <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      alu_q      <= '0;
      pc4_q      <= '0;
      inst_q     <= '0;
      wb_valid_q <= 1'b0;
      wb_alu_q   <= '0;
      wb_pc4_q   <= '0;
      wb_ld_q    <= '0;
      wb_inst_q  <= '0;
      wb_err_q   <= 1'b0;
    end else begin
      if (wb_valid_q && wb_ready_i) wb_valid_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (acc && is_mem && !bad) begin
            state_q <= S_REQ;
            req_q   <= 1'b1;
            we_q    <= is_st;
            be_q    <= be_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            alu_q   <= alu_i;
            pc4_q   <= pc4_d;
            inst_q  <= inst_i;
          end else if (acc) begin
            wb_valid_q <= 1'b1;
            wb_alu_q   <= alu_i;
            wb_pc4_q   <= pc4_d;
            wb_ld_q    <= '0;
            wb_inst_q  <= inst_i;
            wb_err_q   <= bad;
          end
        end
        S_REQ: begin
          if (dmem_gnt_i || flush_i) begin
            req_q <= 1'b0;
            we_q  <= 1'b0;
            be_q  <= '0;
          end
          if (dmem_gnt_i && we_q) begin
            state_q <= S_IDLE;
            if (!flush_i) begin
              wb_valid_q <= 1'b1;
              wb_alu_q   <= alu_q;
              wb_pc4_q   <= pc4_q;
              wb_ld_q    <= '0;
              wb_inst_q  <= inst_q;
              wb_err_q   <= 1'b0;
            end
          end else if (dmem_gnt_i) begin
            state_q <= flush_i ? S_DRAIN : S_WAIT_R;
          end else if (flush_i) begin
            state_q <= S_IDLE;
          end
        end
        S_WAIT_R: begin
          // a response arriving with the flush is already drained
          if (dmem_rvalid_i) begin
            state_q <= S_IDLE;
            if (!flush_i) begin
              wb_valid_q <= 1'b1;
              wb_alu_q   <= alu_q;
              wb_pc4_q   <= pc4_q;
              wb_ld_q    <= ld_data;
              wb_inst_q  <= inst_q;
              wb_err_q   <= 1'b0;
            end
          end else if (flush_i) begin
            state_q <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (dmem_rvalid_i) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign dmem_req_o   = req_q;
  assign dmem_we_o    = we_q;
  assign dmem_addr_o  = addr_q;
  assign dmem_be_o    = be_q;
  assign dmem_wdata_o = wdata_q;
  assign wb_valid_o   = wb_valid_q;
  assign wb_alu_o     = wb_alu_q;
  assign wb_pc4_o     = wb_pc4_q;
  assign wb_ld_o      = wb_ld_q;
  assign wb_inst_o    = wb_inst_q;
  assign wb_err_o     = wb_err_q;

endmodule

// File: tb/tb_mem_stage_hs.sv
// Randomized bench for mem_stage_hs against a transaction-level
// model of the WB results and memory request fields.
module tb_mem_stage_hs;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [31:0] pc_i, alu_i, st_data_i, inst_i;
  logic        flush_i;
  logic        dmem_req_o, dmem_we_o;
  logic [31:0] dmem_addr_o;
  logic [3:0]  dmem_be_o;
  logic [31:0] dmem_wdata_o;
  logic        dmem_gnt_i, dmem_rvalid_i;
  logic [31:0] dmem_rdata_i;
  logic        wb_valid_o;
  logic        wb_ready_i = 1'b0;
  logic [31:0] wb_alu_o, wb_pc4_o, wb_ld_o, wb_inst_o;
  logic        wb_err_o;

  typedef struct {
    logic [31:0] alu;
    logic [31:0] pc4;
    logic [31:0] ld;
    logic [31:0] inst;
    logic        err;
  } wb_t;

  wb_t exq[$];
  int  n_chk = 0;
  int  n_pass = 0;
  int  rdy_mode = 0;

  mem_stage_hs #(.XLEN(32), .ADDR_W(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .pc_i(pc_i), .alu_i(alu_i), .st_data_i(st_data_i),
    .inst_i(inst_i), .flush_i(flush_i),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o),
    .dmem_addr_o(dmem_addr_o), .dmem_be_o(dmem_be_o),
    .dmem_wdata_o(dmem_wdata_o), .dmem_gnt_i(dmem_gnt_i),
    .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i),
    .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i),
    .wb_alu_o(wb_alu_o), .wb_pc4_o(wb_pc4_o), .wb_ld_o(wb_ld_o),
    .wb_inst_o(wb_inst_o), .wb_err_o(wb_err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic bit legal(input bit ld, input int f3);
    if (ld) return f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5;
    return f3 <= 2;
  endfunction

  function automatic logic [31:0] exp_be(input int sz, input int a);
    return 32'(((1 << sz) - 1) << (a % 4));
  endfunction

  function automatic logic [31:0] exp_wd(input logic [31:0] d,
                                         input int sz);
    logic [31:0] r = 0;
    for (int i = 0; i < 4; i++)
      r = r | (((d >> (8 * (i % sz))) & 32'hFF) << (8 * i));
    return r;
  endfunction

  function automatic logic [31:0] exp_ld(input logic [31:0] rd,
                                         input int a, input int f3);
    int          sz = 1 << (f3 % 4);
    logic [31:0] m, v;
    m = (sz == 4) ? 32'hFFFF_FFFF : 32'((1 << (8 * sz)) - 1);
    v = (rd >> (8 * (a % 4))) & m;
    if (f3 < 4 && v[8*sz-1]) v = v | ~m;
    return v;
  endfunction

  always @(posedge clk_i) begin
    #2;
    if (rdy_mode == 2) wb_ready_i = ($urandom % 4) != 0;
    else wb_ready_i = (rdy_mode == 1);
  end

  logic        pv = 1'b0;
  logic [31:0] p_alu, p_pc4, p_ld, p_inst;
  logic        p_err;

  always @(negedge clk_i) begin
    wb_t e;
    if (rst_i) begin
      pv = 1'b0;
    end else begin
      if (pv) begin
        chk("hold_alu", wb_alu_o, p_alu);
        chk("hold_ld", wb_ld_o, p_ld);
        chk("hold_pc4", wb_pc4_o, p_pc4);
        chk("hold_v", 32'(wb_valid_o), 32'd1);
      end
      if (wb_valid_o && wb_ready_i) begin
        if (exq.size() == 0) begin
          chk("wb_extra", 32'(wb_valid_o), 32'd0);
        end else begin
          e = exq.pop_front();
          chk("wb_alu", wb_alu_o, e.alu);
          chk("wb_pc4", wb_pc4_o, e.pc4);
          chk("wb_ld", wb_ld_o, e.ld);
          chk("wb_inst", wb_inst_o, e.inst);
          chk("wb_err", 32'(wb_err_o), 32'(e.err));
        end
      end
      pv = wb_valid_o && !wb_ready_i;
      p_alu = wb_alu_o; p_pc4 = wb_pc4_o;
      p_ld = wb_ld_o; p_inst = wb_inst_o; p_err = wb_err_o;
    end
  end

  // fm: 0 none, 1 flush in REQ before gnt, 2 flush with gnt,
  // 3 flush in WAIT_R
  task automatic send(input logic [31:0] inst, input logic [31:0] alu,
                      input logic [31:0] sd, input logic [31:0] pc,
                      input int gd, input int rd, input int fm,
                      input logic [31:0] rdat);
    bit  ld, st, bad;
    int  sz, t;
    wb_t e;
    ld = inst[6:0] == 7'h03;
    st = inst[6:0] == 7'h23;
    sz = 1 << inst[13:12];
    bad = (ld || st) && (!legal(ld, int'(inst[14:12])) || (alu % sz) != 0);
    if (st && fm == 3) fm = 0;
    e.alu = alu; e.pc4 = pc + 32'd4; e.inst = inst;
    e.ld = 32'd0; e.err = bad;
    @(negedge clk_i);
    in_valid_i = 1'b1; inst_i = inst; alu_i = alu;
    st_data_i = sd; pc_i = pc;
    t = 0;
    while (!in_ready_o && t < 500) begin @(negedge clk_i); t++; end
    chk("acc_to", 32'(t < 500), 32'd1);
    if (!(ld || st) || bad) begin
      exq.push_back(e);
      @(negedge clk_i);
      in_valid_i = 1'b0;
      chk("lat1", 32'(wb_valid_o), 32'd1);
      chk("noreq", 32'(dmem_req_o), 32'd0);
      return;
    end
    @(negedge clk_i);
    in_valid_i = 1'b0;
    for (int c = 0; c <= gd; c++) begin
      chk("req", 32'(dmem_req_o), 32'd1);
      chk("we", 32'(dmem_we_o), 32'(st));
      chk("addr", dmem_addr_o, alu & ~32'd3);
      chk("be", 32'(dmem_be_o), exp_be(sz, int'(alu[1:0])));
      if (st) chk("wdata", dmem_wdata_o, exp_wd(sd, sz));
      dmem_rvalid_i = ($urandom % 4) == 0;
      if (c == gd) begin
        if (fm == 1) begin
          flush_i = 1'b1;
        end else begin
          dmem_gnt_i = 1'b1;
          flush_i = (fm == 2);
          if (st && fm == 0) exq.push_back(e);
        end
      end
      @(negedge clk_i);
    end
    dmem_gnt_i = 1'b0; flush_i = 1'b0; dmem_rvalid_i = 1'b0;
    chk("req_off", 32'(dmem_req_o), 32'd0);
    if (st || fm == 1) begin
      chk("st_wbv", 32'(wb_valid_o), 32'(st && fm == 0));
      return;
    end
    if (fm == 3) begin
      flush_i = 1'b1;
      @(negedge clk_i);
      flush_i = 1'b0;
    end
    repeat (rd) @(negedge clk_i);
    dmem_rvalid_i = 1'b1;
    dmem_rdata_i = rdat;
    if (fm == 0) begin
      e.ld = exp_ld(rdat, int'(alu[1:0]), int'(inst[14:12]));
      exq.push_back(e);
    end
    @(negedge clk_i);
    dmem_rvalid_i = 1'b0;
    dmem_rdata_i = $urandom;
    chk("ld_wbv", 32'(wb_valid_o), 32'(fm == 0));
    if (fm != 0) chk("ld_rdy", 32'(in_ready_o), 32'd1);
  endtask

  initial begin
    int          t, k, f3, sz, fm;
    logic [31:0] inst, addr;
    rst_i = 1'b1; in_valid_i = 1'b0; flush_i = 1'b0;
    pc_i = 0; alu_i = 0; st_data_i = 0; inst_i = 0;
    dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = 0;
    repeat (3) @(negedge clk_i);
    chk("rst_wbv", 32'(wb_valid_o), 32'd0);
    chk("rst_req", 32'(dmem_req_o), 32'd0);
    chk("rst_we", 32'(dmem_we_o), 32'd0);
    chk("rst_be", 32'(dmem_be_o), 32'd0);
    chk("rst_err", 32'(wb_err_o), 32'd0);
    chk("rst_alu", wb_alu_o, 32'd0);
    chk("rst_addr", dmem_addr_o, 32'd0);
    rst_i = 1'b0;
    rdy_mode = 1;
    @(negedge clk_i);

    send(32'h0000_0033, 32'h1234, 0, 32'h100, 0, 0, 0, 0);
    send(32'h0000_0033, 32'h55, 0, 32'hFFFF_FFFC, 0, 0, 0, 0);
    send(32'h0000_0023, 32'h1003, 32'hAB, 32'h200, 3, 0, 0, 0);
    send(32'h0000_0003, 32'h2001, 0, 32'h204, 1, 2, 0, 32'h0000_80FF);
    send(32'h0000_4003, 32'h2001, 0, 32'h208, 0, 2, 0, 32'h0000_80FF);
    send(32'h0000_2003, 32'h2002, 0, 32'h20C, 0, 0, 0, 0);
    send(32'h0000_2003, 32'h2000, 0, 32'h210, 1, 2, 3, 32'hDEAD_BEEF);
    send(32'h0000_2003, 32'h2004, 0, 32'h214, 0, 1, 1, 0);
    send(32'h0000_1023, 32'h2006, 32'h1234_5678, 32'h218, 0, 0, 2, 0);

    @(negedge clk_i);
    in_valid_i = 1'b1; flush_i = 1'b1; inst_i = 32'h0000_0013;
    @(negedge clk_i);
    in_valid_i = 1'b0; flush_i = 1'b0;
    chk("idle_flush", 32'(wb_valid_o), 32'd0);

    rdy_mode = 0;
    repeat (2) @(negedge clk_i);
    send(32'h0000_0033, 32'hCAFE, 0, 32'h300, 0, 0, 0, 0);
    repeat (5) begin
      chk("bp_rdy", 32'(in_ready_o), 32'd0);
      chk("bp_v", 32'(wb_valid_o), 32'd1);
      @(negedge clk_i);
    end
    rdy_mode = 1;
    @(negedge clk_i);
    chk("bp_acc", 32'(in_ready_o & wb_valid_o), 32'd1);

    rdy_mode = 2;
    for (int n = 0; n < 300; n++) begin
      k = $urandom % 3;
      f3 = $urandom % 8;
      inst = $urandom;
      if (k == 0) begin
        if (inst[6:0] == 7'h03 || inst[6:0] == 7'h23) inst[6:0] = 7'h33;
      end else begin
        inst[6:0] = (k == 1) ? 7'h03 : 7'h23;
      end
      inst[14:12] = 3'(f3);
      sz = 1 << (f3 % 4);
      addr = 32'h4000 + ($urandom % 64);
      if ($urandom % 2) addr = addr & ~32'(sz - 1);
      fm = (($urandom % 5) == 0) ? 1 + int'($urandom % 3) : 0;
      send(inst, addr, $urandom, $urandom, $urandom % 4,
           $urandom % 4, fm, $urandom);
      repeat ($urandom % 3) begin
        dmem_rvalid_i = $urandom % 2;
        @(negedge clk_i);
      end
      dmem_rvalid_i = 1'b0;
    end

    t = 0;
    while (exq.size() != 0 && t < 200) begin @(negedge clk_i); t++; end
    chk("drain", 32'(exq.size()), 32'd0);

    rdy_mode = 1;
    repeat (3) @(negedge clk_i);
    in_valid_i = 1'b1; inst_i = 32'h0000_2003; alu_i = 32'h5000;
    t = 0;
    while (!in_ready_o && t < 50) begin @(negedge clk_i); t++; end
    @(negedge clk_i);
    in_valid_i = 1'b0; dmem_gnt_i = 1'b1;
    @(negedge clk_i);
    dmem_gnt_i = 1'b0; rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0; dmem_rvalid_i = 1'b1;
    @(negedge clk_i);
    dmem_rvalid_i = 1'b0;
    chk("mid_rst_wbv", 32'(wb_valid_o), 32'd0);
    chk("mid_rst_rdy", 32'(in_ready_o), 32'd1);
    chk("mid_rst_req", 32'(dmem_req_o), 32'd0);
    repeat (2) @(negedge clk_i);
    chk("mid_rst_q", 32'(exq.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_stage_hs.md
MEM_STAGE_HS -- requirements
Module: mem_stage_hs

Interface
REQ-001 Parameter XLEN, default 32, data width; legal values 32 and 64 only.
REQ-002 Parameter ADDR_W, default 32, data-memory address width.
REQ-003 clk_i  in  1  single clock; all state updates on rising edge.
REQ-004 rst_i  in  1  reset, synchronous, active-high.
REQ-005 in_valid_i  in  1  / in_ready_o  out  1  upstream (EX) handshake.
REQ-006 pc_i  in  ADDR_W; alu_i  in  XLEN (effective address or result); st_data_i  in  XLEN; inst_i  in  32.
REQ-007 flush_i  in  1  kills the in-flight operation.
REQ-008 dmem_req_o  out  1; dmem_we_o  out  1; dmem_addr_o  out  ADDR_W (XLEN/8-aligned); dmem_be_o  out  XLEN/8; dmem_wdata_o  out  XLEN.
REQ-009 dmem_gnt_i  in  1; dmem_rvalid_i  in  1; dmem_rdata_i  in  XLEN.
REQ-010 wb_valid_o  out  1 / wb_ready_i  in  1  downstream (WB) handshake.
REQ-011 wb_alu_o  out  XLEN; wb_pc4_o  out  ADDR_W; wb_ld_o  out  XLEN; wb_inst_o  out  32; wb_err_o  out  1.

Function
REQ-012 Operation class SHALL come from inst_i[6:0]: 0000011 = load, 0100011 = store, all other opcodes = pass-through.
REQ-013 in_ready_o SHALL be 1 only when state = IDLE and (wb_valid_o = 0 or wb_ready_i = 1).
REQ-014 The FSM SHALL have states IDLE, REQ, WAIT_R and DRAIN.
REQ-015 Pass-through, misaligned and unsupported-width operations SHALL stay in IDLE.
- They load the WB register one cycle after acceptance (latency 1).
- wb_ld_o = 0.
REQ-016 An aligned load or store accepted in IDLE SHALL move to REQ.
- In REQ, dmem_req_o = 1.
- addr, we, be and wdata SHALL be held stable until dmem_gnt_i = 1.
REQ-017 Store in REQ with gnt = 1 SHALL load the WB register in the same edge and return to IDLE; no response is expected.
REQ-018 Load in REQ with gnt = 1 SHALL move to WAIT_R.
- WAIT_R with rvalid = 1 SHALL load the WB register with the extended data and return to IDLE.
REQ-019 Byte-lane rules, lane = alu_i low bits:
- be SB = 1 << lane; SH = 3 << lane; SW = 0xF << lane; SD = all ones.
- wdata SHALL replicate the stored byte, half or word across all lanes.
REQ-020 Load extension by func3 (inst_i[14:12]), selecting the lane from the stored address:
- 000 LB sign; 001 LH sign; 010 LW sign (zero for XLEN = 32); 100 LBU zero; 101 LHU zero.
- 011 LD/SD and 110 LWU are legal only when XLEN = 64.
REQ-021 Misaligned access SHALL issue no request and SHALL set wb_err_o = 1.
- Misaligned means: half with addr[0] = 1; word with addr[1:0] != 0; double with addr[2:0] != 0.
- An illegal func3 is treated the same way.
REQ-022 wb_pc4_o SHALL equal pc_i + 4, modulo 2^ADDR_W (wrap-around allowed).
REQ-023 The WB register SHALL hold its contents while wb_valid_o = 1 and wb_ready_i = 0.
- wb_valid_o SHALL clear on a handshake unless a new result loads in the same edge.
REQ-024 flush_i behaviour by state:
- IDLE: blocks acceptance that cycle.
- REQ with gnt = 0: drop the request, go to IDLE, no WB write.
- REQ with gnt = 1 and load: go to DRAIN.
- REQ with gnt = 1 and store: the store completes, but the WB write is suppressed.
- WAIT_R: go to DRAIN.
- DRAIN: wait for rvalid, discard the data, go to IDLE.
- flush_i SHALL never clear an already-valid WB register.
REQ-025 dmem_rvalid_i in IDLE or REQ SHALL be ignored.

Reset
REQ-026 On rst_i = 1 at a clock edge, the block SHALL go to IDLE.
- wb_valid_o = 0, dmem_req_o = 0, dmem_we_o = 0, dmem_be_o = 0, wb_err_o = 0.
- All data outputs SHALL be 0.
REQ-027 Reset mid-transaction SHALL abandon it with no WB write; a later stray rvalid is ignored per REQ-025.

Structure
REQ-028 Package mem_stage_pkg SHALL hold:
- opcode constants, the func3 enum and the FSM state enum;
- the be/misalign helper functions.
REQ-029 One sub-module, mem_ld_align, SHALL hold the combinational lane-select and extension logic (XLEN-parametrised).

Verification
REQ-030 Pass-through: ADD with alu = 0x1234, pc = 0x100, wb_ready = 1 -> wb_valid is 1 one cycle later, wb_alu = 0x1234, wb_pc4 = 0x104, wb_err = 0.
REQ-031 SB at addr 0x1003, data 0xAB, gnt delayed 3 cycles -> req held 4 cycles with be = 0x8 and wdata = 0xABABABAB; wb_valid appears on the cycle after gnt.
REQ-032 LB at 0x2001 with rdata 0x0000_80FF, rvalid 2 cycles after gnt -> wb_ld = 0xFFFF_FF80; LBU at the same address -> 0x0000_0080.
REQ-033 LW at 0x2002 -> no dmem_req, wb_err = 1, latency 1.
REQ-034 LW with flush in WAIT_R -> DRAIN; rvalid 0xDEAD_BEEF is discarded; no WB write; the next op is accepted the cycle after rvalid.
REQ-035 WB backpressure: wb_ready = 0 for 5 cycles with wb_valid = 1 -> in_ready = 0, WB outputs stable; then wb_ready = 1 -> handshake, and acceptance resumes the same cycle.
